// File: rtl/ctl_reg_reader.sv
// Purpose : polls the controller BRAM flag word and streams each newly flagged register group out.
// Latency : register data appears READ_LATENCY cycles after its address; GROUP_DONE follows the last register by one cycle.
// Backpressure: none. The stream is a free-running strobe, so consumers must accept one register per cycle.
//
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   bram_en_o/we_o        BRAM port B enable / write enable (write only for FPGA_STATE)
//   bram_addr_o/din_o     BRAM port B address / write data
//   bram_dout_i           BRAM port B read data (READ_LATENCY cycles after address)
//   status_in_i           status bits written to FPGA_STATE[6:0] once per pass
//   ctl_flag_o            last ADDR_CTL_FLAG snapshot
//   reg_valid_o/addr_o/data_o/group_o   one-cycle register stream strobe and payload
//   group_done_o/group_id_o             one-cycle strobe after the last register of a group
module ctl_reg_reader #(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        bram_en_o,
  output logic        bram_we_o,
  output logic [7:0]  bram_addr_o,
  output logic [15:0] bram_din_o,
  input  logic [15:0] bram_dout_i,
  input  logic [6:0]  status_in_i,
  output logic [15:0] ctl_flag_o,
  output logic        reg_valid_o,
  output logic [7:0]  reg_addr_o,
  output logic [15:0] reg_data_o,
  output logic [2:0]  reg_group_o,
  output logic        group_done_o,
  output logic [2:0]  group_id_o
);

  localparam logic [7:0] ADDR_CTL_FLAG   = 8'h00;
  localparam logic [7:0] ADDR_FPGA_STATE = 8'h01;
  localparam logic [1:0] LAT_LAST        = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_RD_CTL,
    S_RD_WAIT,
    S_SELECT,
    S_BURST,
    S_DRAIN,
    S_WR_STATE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;        // wait/drain cycle counter
  logic [4:0]  idx_q, idx_d;        // register index within the current burst
  logic [2:0]  grp_q, grp_d;        // group being streamed
  logic [5:0]  pending_q, pending_d;
  logic [5:0]  prev_q, prev_d;      // flag bits of the previous snapshot, for edge detection
  logic [15:0] ctl_flag_q, ctl_flag_d;
  logic        done_q, done_d;

  logic        en_c, we_c;
  logic [7:0]  addr_c;
  logic [15:0] din_c;
  logic        issue_vld;
  logic [7:0]  issue_addr;
  logic [2:0]  sel_bit;

  // Address pipe: tags each returning BRAM word with the address that fetched it.
  logic [READ_LATENCY-1:0] pvld_q;
  logic [7:0]              paddr_q [READ_LATENCY];

  function automatic logic [7:0] grp_base(input logic [2:0] g);
    case (g)
      3'd0:    return 8'h20;
      3'd1:    return 8'h50;
      3'd2:    return 8'h40;
      3'd3:    return 8'hE0;
      3'd4:    return 8'hF0;
      3'd5:    return 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [4:0] grp_count(input logic [2:0] g);
    case (g)
      3'd0:    return 5'd17;
      3'd1:    return 5'd25;
      3'd2:    return 5'd5;
      3'd3:    return 5'd2;
      3'd4:    return 5'd8;
      3'd5:    return 5'd6;
      default: return 5'd1;
    endcase
  endfunction

  // Lowest set pending bit wins, so simultaneous edges are serviced in ascending order.
  always_comb begin
    sel_bit = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pending_q[i]) sel_bit = 3'(i);
    end
  end

  assign issue_addr = grp_base(grp_q) + {3'b000, idx_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    grp_d      = grp_q;
    pending_d  = pending_q;
    prev_d     = prev_q;
    ctl_flag_d = ctl_flag_q;
    done_d     = 1'b0;
    en_c       = 1'b0;
    we_c       = 1'b0;
    addr_c     = 8'h00;
    din_c      = 16'h0000;
    issue_vld  = 1'b0;

    case (state_q)
      S_RD_CTL: begin
        en_c    = 1'b1;
        addr_c  = ADDR_CTL_FLAG;
        cnt_d   = 2'd0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          ctl_flag_d = bram_dout_i;
          pending_d  = pending_q | (bram_dout_i[5:0] & ~prev_q);
          prev_d     = bram_dout_i[5:0];
          state_d    = S_SELECT;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_SELECT: begin
        if (pending_q != 6'd0) begin
          grp_d     = sel_bit;
          pending_d = pending_q & ~(6'b000001 << sel_bit);
          idx_d     = 5'd0;
          state_d   = S_BURST;
        end else begin
          state_d = S_WR_STATE;
        end
      end
      S_BURST: begin
        en_c      = 1'b1;
        addr_c    = issue_addr;
        issue_vld = 1'b1;
        if (idx_q == grp_count(grp_q) - 5'd1) begin
          cnt_d   = 2'd0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_DRAIN: begin
        // The last word lands in the final drain cycle; done is registered into the next one.
        if (cnt_q == LAT_LAST) begin
          done_d  = 1'b1;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WR_STATE: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = ADDR_FPGA_STATE;
        din_c   = {9'h000, status_in_i};
        state_d = S_RD_CTL;
      end
      default: state_d = S_RD_CTL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_RD_CTL;
      cnt_q      <= 2'd0;
      idx_q      <= 5'd0;
      grp_q      <= 3'd0;
      pending_q  <= 6'd0;
      prev_q     <= 6'd0;
      ctl_flag_q <= 16'h0000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      grp_q      <= grp_d;
      pending_q  <= pending_d;
      prev_q     <= prev_d;
      ctl_flag_q <= ctl_flag_d;
      done_q     <= done_d;
    end
  end

  // Clearing the pipe on reset drops reads still in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pvld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) paddr_q[i] <= 8'h00;
    end else begin
      pvld_q[0]  <= issue_vld;
      paddr_q[0] <= issue_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pvld_q[i]  <= pvld_q[i-1];
        paddr_q[i] <= paddr_q[i-1];
      end
    end
  end

  // Outputs are held low while reset is asserted so nothing reaches the BRAM or latches.
  assign bram_en_o    = en_c & ~rst_i;
  assign bram_we_o    = we_c & ~rst_i;
  assign bram_addr_o  = rst_i ? 8'h00 : addr_c;
  assign bram_din_o   = rst_i ? 16'h0000 : din_c;
  assign ctl_flag_o   = ctl_flag_q;
  assign reg_valid_o  = pvld_q[READ_LATENCY-1] & ~rst_i;
  assign reg_addr_o   = reg_valid_o ? paddr_q[READ_LATENCY-1] : 8'h00;
  assign reg_data_o   = reg_valid_o ? bram_dout_i : 16'h0000;
  assign reg_group_o  = reg_valid_o ? grp_q : 3'd0;
  assign group_done_o = done_q & ~rst_i;
  assign group_id_o   = group_done_o ? grp_q : 3'd0;

endmodule

// File: tb/tb_ctl_reg_reader.sv
module tb_ctl_reg_reader;

  typedef struct packed {
    logic [1:0]  inst;
    logic        kind;   // 0 = register strobe, 1 = group done
    logic [7:0]  a;
    logic [15:0] d;
    logic [2:0]  g;
    logic [31:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic [6:0]  status;
  logic        en [3], we [3], rv [3], gd [3];
  logic [7:0]  addr [3], ra [3];
  logic [15:0] din [3], dout [3], ctl [3], rd [3];
  logic [2:0]  rg [3], gi [3];
  logic [15:0] mem [3][256];

  // Three instances with READ_LATENCY 1..3; only one is out of reset at a time.
  for (genvar k = 0; k < 3; k++) begin : g_inst
    logic [15:0] bp0, bp1, bp2;
    ctl_reg_reader #(.READ_LATENCY(k+1)) u_dut (
      .clk_i(clk), .rst_i(rst[k]),
      .bram_en_o(en[k]), .bram_we_o(we[k]), .bram_addr_o(addr[k]), .bram_din_o(din[k]),
      .bram_dout_i(dout[k]), .status_in_i(status), .ctl_flag_o(ctl[k]),
      .reg_valid_o(rv[k]), .reg_addr_o(ra[k]), .reg_data_o(rd[k]), .reg_group_o(rg[k]),
      .group_done_o(gd[k]), .group_id_o(gi[k])
    );
    always @(posedge clk) begin
      if (en[k] && !we[k]) bp0 <= mem[k][addr[k]];
      bp1 <= bp0;
      bp2 <= bp1;
    end
    assign dout[k] = (k == 0) ? bp0 : (k == 1) ? bp1 : bp2;
  end

  function automatic ev_t mk_ev(int k, bit kind, logic [7:0] a, logic [15:0] d, logic [2:0] g, int c);
    ev_t e;
    e.inst = 2'(k); e.kind = kind; e.a = a; e.d = d; e.g = g; e.cyc = 32'(c);
    return e;
  endfunction

  // Bus monitor
  int          cyc = 0;
  int          proto_bad [3] = '{0, 0, 0};
  int          wr_since [3] = '{0, 0, 0};
  int          wr_total [3] = '{0, 0, 0};
  bit          seen_rd [3] = '{0, 0, 0};
  logic [15:0] last_wr [3];
  int          rd40_cyc [3] = '{0, 0, 0};
  int          done_cyc [3] = '{0, 0, 0};
  ev_t         obsq [$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        seen_rd[k]  = 0;
        wr_since[k] = 0;
      end
      if (rv[k]) obsq.push_back(mk_ev(k, 1'b0, ra[k], rd[k], rg[k], cyc));
      if (gd[k]) begin
        obsq.push_back(mk_ev(k, 1'b1, 8'h00, 16'h0000, gi[k], cyc));
        done_cyc[k] = cyc;
      end
      if (we[k]) begin
        if (!(en[k] && addr[k] == 8'h01 && din[k] == {9'h000, status})) proto_bad[k]++;
        wr_since[k]++;
        wr_total[k]++;
        last_wr[k] = din[k];
      end
      if (en[k] && !we[k] && addr[k] == 8'h40) rd40_cyc[k] = cyc;
      if (en[k] && !we[k] && addr[k] == 8'h00) begin
        if (seen_rd[k] && wr_since[k] != 1) proto_bad[k]++;
        seen_rd[k]  = 1;
        wr_since[k] = 0;
      end
    end
  end

  // Reference model and checking
  int          n_chk = 0;
  int          n_err = 0;
  int          base_t [6] = '{'h20, 'h50, 'h40, 'hE0, 'hF0, 'h10};
  int          cnt_t [6]  = '{17, 25, 5, 2, 8, 6};
  logic [15:0] prev_m [3];
  ev_t         expq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] sig(ev_t e);
    return {4'h0, e.kind, e.a, e.d, e.g};
  endfunction

  task automatic expect_group(input int k, input int b, input int upto);
    for (int i = 0; i < upto; i++)
      expq.push_back(mk_ev(k, 1'b0, 8'(base_t[b] + i), mem[k][base_t[b] + i], 3'(b), 0));
  endtask

  task automatic expect_done(input int k, input int b);
    expq.push_back(mk_ev(k, 1'b1, 8'h00, 16'h0000, 3'(b), 0));
  endtask

  task automatic compare_phase(input int k, input string tag, input bit chk_t);
    ev_t got [$];
    int  tbad = 0;
    int  errs = 0;
    foreach (obsq[i]) if (obsq[i].inst == 2'(k)) got.push_back(obsq[i]);
    obsq.delete();
    check({tag, "_nevents"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size() && errs < 3; i++) begin
      if (sig(got[i]) !== sig(expq[i])) errs++;
      check({tag, "_event"}, sig(got[i]), sig(expq[i]));
    end
    if (chk_t) begin
      for (int i = 0; i < got.size(); i++) begin
        if (got[i].kind) begin
          if (i == 0 || got[i-1].kind || got[i].cyc != got[i-1].cyc + 1) tbad++;
        end else if (i > 0 && !got[i-1].kind && got[i].g == got[i-1].g) begin
          if (got[i].cyc != got[i-1].cyc + 1) tbad++;
        end
      end
      check({tag, "_contiguous"}, 32'(tbad), 32'd0);
    end
    expq.delete();
  endtask

  // Apply a new flag word, predict the bursts from rising bits, and compare after settling.
  task automatic run_phase(input int k, input logic [15:0] f, input int ncyc, input string tag);
    for (int b = 0; b < 6; b++) begin
      if (f[b] && !prev_m[k][b]) begin
        expect_group(k, b, cnt_t[b]);
        expect_done(k, b);
      end
    end
    mem[k][0] = f;
    tick(ncyc);
    compare_phase(k, tag, 1'b1);
    check({tag, "_ctl_flag"}, 32'(ctl[k]), 32'(f));
    prev_m[k] = f;
  endtask

  initial begin
    int w0;
    int wt;
    status = 7'h00;
    for (int k = 0; k < 3; k++) begin
      rst[k]    = 1'b1;
      prev_m[k] = 16'h0000;
      for (int a = 0; a < 256; a++) mem[k][a] = 16'($urandom);
      mem[k][0] = 16'h0000;
    end
    tick(3);

    // Reset state
    check("rst_en", 32'(en[1]), 32'd0);
    check("rst_we", 32'(we[1]), 32'd0);
    check("rst_ctl_flag", 32'(ctl[1]), 32'd0);
    check("rst_reg_valid", 32'(rv[1]), 32'd0);
    check("rst_group_done", 32'(gd[1]), 32'd0);
    check("rst_group_id", 32'(gi[1]), 32'd0);
    rst[1] = 1'b0;

    // Single silencer burst with known data
    for (int a = 0; a < 5; a++) mem[1][8'h40 + a] = 16'(a + 1);
    status = 7'h11;
    run_phase(1, 16'h0004, 300, "t1_silencer");

    // Held flag fires once; re-fires only after a zero snapshot
    run_phase(1, 16'h0004, 300, "t2_held");
    run_phase(1, 16'h0000, 300, "t2_clear");
    run_phase(1, 16'h0004, 300, "t2_refire");

    // FPGA_STATE write-back
    status = 7'h5A;
    w0 = wr_total[1];
    tick(100);
    check("t4_wr_data", 32'(last_wr[1]), 32'h005A);
    check("t4_wr_seen", 32'(wr_total[1] > w0), 32'd1);

    // Simultaneous edges, ascending order
    run_phase(1, 16'h0000, 300, "t3_clear");
    run_phase(1, 16'h0023, 300, "t3_multi");

    // Random flag words, register contents and status
    for (int r = 0; r < 8; r++) begin
      for (int a = 1; a < 256; a++) mem[1][a] = 16'($urandom);
      status = 7'($urandom);
      run_phase(1, 16'($urandom), 300, "rand");
    end

    // Reset mid-burst
    run_phase(1, 16'h0000, 300, "t5_clear");
    expect_group(1, 1, 10);
    expect_group(1, 1, 25);
    expect_done(1, 1);
    mem[1][0] = 16'h0002;
    wt = 0;
    while (obsq.size() < 10 && wt < 400) begin
      tick(1);
      wt++;
    end
    check("t5_tenth_strobe", 32'(obsq.size()), 32'd10);
    rst[1] = 1'b1;
    tick(3);
    check("t5_quiet_in_reset", 32'(obsq.size()), 32'd10);
    check("t5_rst_ctl_flag", 32'(ctl[1]), 32'd0);
    rst[1] = 1'b0;
    tick(300);
    compare_phase(1, "t5_restart", 1'b0);
    prev_m[1] = 16'h0002;
    check("proto_main", 32'(proto_bad[1]), 32'd0);
    rst[1] = 1'b1;
    tick(2);

    // Latency sweep with the silencer burst
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 5; a++) mem[k][8'h40 + a] = 16'(a + 1);
      mem[k][0] = 16'h0000;
      prev_m[k] = 16'h0000;
      obsq.delete();
      rst[k] = 1'b0;
      tick(2);
      run_phase(k, 16'h0004, 200, $sformatf("sweep_l%0d", k + 1));
      check($sformatf("sweep_l%0d_burst_to_done", k + 1), 32'(done_cyc[k] - rd40_cyc[k]), 32'(5 + k + 1));
      check($sformatf("sweep_l%0d_proto", k + 1), 32'(proto_bad[k]), 32'd0);
      rst[k] = 1'b1;
      tick(2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
